// File: rtl/fp_adder_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready handshake and global stall.
// Subnormal inputs are read as signed zero; results too small to normalise flush to zero.
module fp_adder_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] s,
    output logic                 ovf,
    output logic                 unf,
    output logic                 nan
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 4;
    localparam int LZ_W  = $clog2(SIG_W) + 1;
    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W:0]   SH_MAX   = (EXP_W+1)'(MAN_W + 3);

    typedef struct packed {
        logic             vld;
        logic             sx;
        logic             sy;
        logic [EXP_W-1:0] ex;
        logic [SIG_W-1:0] mx;
        logic [SIG_W-1:0] my;
        logic             nan;
        logic             inf;
        logic             inf_sgn;
    } s1_t;

    typedef struct packed {
        logic             vld;
        logic             sgn;
        logic             zsgn;
        logic [EXP_W-1:0] ex;
        logic [SIG_W:0]   sum;
        logic             nan;
        logic             inf;
        logic             inf_sgn;
    } s2_t;

    typedef struct packed {
        logic         vld;
        logic [W-1:0] res;
        logic         ovf;
        logic         unf;
        logic         nan;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    logic stall_s;

    logic               sa_s, sb_s, zero_a_s, zero_b_s, swap_s;
    logic               inf_a_s, inf_b_s, nan_a_s, nan_b_s;
    logic [W-2:0]       mag_a_s, mag_b_s, mag_x_s, mag_y_s;
    logic [MAN_W:0]     sig_x_s, sig_y_s;
    logic [EXP_W:0]     diff_s, shamt_s;
    logic [2*MAN_W+3:0] y_wide_s;

    logic [LZ_W-1:0]    lz_s;
    logic [SIG_W-2:0]   nm_s;
    logic [EXP_W+1:0]   exp_n_s, exp_r_s;
    logic [MAN_W:0]     mant_r_s;
    logic               round_up_s, nonpos_s;

    assign stall_s   = s3_q.vld & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = s3_q.vld;
    assign s         = s3_q.res;
    assign ovf       = s3_q.ovf;
    assign unf       = s3_q.unf;
    assign nan       = s3_q.nan;

    // Stage 1: classify, order by magnitude, align the smaller significand
    always_comb begin
        sa_s     = a[W-1];
        sb_s     = b[W-1] ^ sub;
        zero_a_s = (a[W-2:MAN_W] == {EXP_W{1'b0}});
        zero_b_s = (b[W-2:MAN_W] == {EXP_W{1'b0}});
        inf_a_s  = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] == {MAN_W{1'b0}});
        inf_b_s  = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] == {MAN_W{1'b0}});
        nan_a_s  = (a[W-2:MAN_W] == EXP_ONES) && (a[MAN_W-1:0] != {MAN_W{1'b0}});
        nan_b_s  = (b[W-2:MAN_W] == EXP_ONES) && (b[MAN_W-1:0] != {MAN_W{1'b0}});
        mag_a_s  = zero_a_s ? {(W-1){1'b0}} : a[W-2:0];
        mag_b_s  = zero_b_s ? {(W-1){1'b0}} : b[W-2:0];
        swap_s   = (mag_b_s > mag_a_s);
        mag_x_s  = swap_s ? mag_b_s : mag_a_s;
        mag_y_s  = swap_s ? mag_a_s : mag_b_s;
        sig_x_s  = (mag_x_s[W-2:MAN_W] == {EXP_W{1'b0}}) ? {(MAN_W+1){1'b0}}
                                                         : {1'b1, mag_x_s[MAN_W-1:0]};
        sig_y_s  = (mag_y_s[W-2:MAN_W] == {EXP_W{1'b0}}) ? {(MAN_W+1){1'b0}}
                                                         : {1'b1, mag_y_s[MAN_W-1:0]};
        diff_s   = {1'b0, mag_x_s[W-2:MAN_W]} - {1'b0, mag_y_s[W-2:MAN_W]};
        // Beyond MAN_W+3 places the whole significand already lands in sticky
        shamt_s  = (diff_s > SH_MAX) ? SH_MAX : diff_s;
        y_wide_s = {sig_y_s, {(MAN_W+3){1'b0}}} >> shamt_s;

        s1_d = s1_q;
        if (!stall_s) begin
            s1_d.vld     = in_valid;
            s1_d.sx      = swap_s ? sb_s : sa_s;
            s1_d.sy      = swap_s ? sa_s : sb_s;
            s1_d.ex      = mag_x_s[W-2:MAN_W];
            s1_d.mx      = {sig_x_s, 3'b000};
            s1_d.my      = {y_wide_s[2*MAN_W+3:MAN_W+1], |y_wide_s[MAN_W:0]};
            s1_d.nan     = nan_a_s | nan_b_s | (inf_a_s & inf_b_s & (sa_s ^ sb_s));
            s1_d.inf     = inf_a_s | inf_b_s;
            s1_d.inf_sgn = inf_a_s ? sa_s : sb_s;
        end else begin
            s1_d = s1_q;
        end
    end

    // Stage 2: signed significand add/subtract; X >= Y so the difference is never negative
    always_comb begin
        s2_d = s2_q;
        if (!stall_s) begin
            s2_d.vld     = s1_q.vld;
            s2_d.sgn     = s1_q.sx;
            s2_d.zsgn    = s1_q.sx & s1_q.sy;
            s2_d.ex      = s1_q.ex;
            s2_d.nan     = s1_q.nan;
            s2_d.inf     = s1_q.inf;
            s2_d.inf_sgn = s1_q.inf_sgn;
            if (s1_q.sx ^ s1_q.sy) begin
                s2_d.sum = {1'b0, s1_q.mx} - {1'b0, s1_q.my};
            end else begin
                s2_d.sum = {1'b0, s1_q.mx} + {1'b0, s1_q.my};
            end
        end else begin
            s2_d = s2_q;
        end
    end

    // Stage 3: normalise, round to nearest even, detect overflow/underflow, pack
    always_comb begin
        lz_s = {LZ_W{1'b0}};
        for (int i = 0; i < SIG_W; i++) begin
            lz_s = s2_q.sum[i] ? LZ_W'(SIG_W - 1 - i) : lz_s;
        end
        // nm_s drops the hidden bit: mantissa, then guard, round, sticky
        if (s2_q.sum[SIG_W]) begin
            nm_s    = {s2_q.sum[SIG_W-1:2], s2_q.sum[1] | s2_q.sum[0]};
            exp_n_s = {2'b00, s2_q.ex} + {{(EXP_W+1){1'b0}}, 1'b1};
        end else begin
            nm_s    = s2_q.sum[SIG_W-2:0] << lz_s;
            exp_n_s = {2'b00, s2_q.ex} - (EXP_W+2)'(lz_s);
        end
        nonpos_s   = exp_n_s[EXP_W+1] | (exp_n_s == {(EXP_W+2){1'b0}});
        round_up_s = nm_s[2] & (nm_s[1] | nm_s[0] | nm_s[3]);
        mant_r_s   = {1'b0, nm_s[SIG_W-2:3]} + {{MAN_W{1'b0}}, round_up_s};
        exp_r_s    = exp_n_s + {{(EXP_W+1){1'b0}}, mant_r_s[MAN_W]};

        s3_d = s3_q;
        if (!stall_s) begin
            s3_d.vld = s2_q.vld;
            s3_d.ovf = 1'b0;
            s3_d.unf = 1'b0;
            s3_d.nan = 1'b0;
            if (s2_q.nan) begin
                s3_d.res = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
                s3_d.nan = 1'b1;
            end else if (s2_q.inf) begin
                s3_d.res = {s2_q.inf_sgn, EXP_ONES, {MAN_W{1'b0}}};
            end else if (s2_q.sum == {(SIG_W+1){1'b0}}) begin
                s3_d.res = {s2_q.zsgn, {(W-1){1'b0}}};
            end else if (nonpos_s) begin
                s3_d.res = {s2_q.sgn, {(W-1){1'b0}}};
                s3_d.unf = 1'b1;
            end else if (exp_r_s >= {2'b00, EXP_ONES}) begin
                s3_d.res = {s2_q.sgn, EXP_ONES, {MAN_W{1'b0}}};
                s3_d.ovf = 1'b1;
            end else begin
                s3_d.res = {s2_q.sgn, exp_r_s[EXP_W-1:0], mant_r_s[MAN_W-1:0]};
            end
        end else begin
            s3_d = s3_q;
        end
    end

    // Pipeline registers; reset drops every in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Directed bench for fp_adder_pipe: vector table, backpressure, mid-flight reset, single-precision build.
module tb_fp_adder_pipe;
    localparam int NV = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready, ovf, unf, nan;
    logic [15:0] a, b, s;
    logic        in_valid32, in_ready32, sub32, out_valid32, out_ready32, ovf32, unf32, nan32;
    logic [31:0] a32, b32, s32;
    int          n_chk, n_err;

    fp_adder_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .ovf(ovf), .unf(unf), .nan(nan)
    );

    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32),
        .s(s32), .ovf(ovf32), .unf(unf32), .nan(nan32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        ovf;
        logic        unf;
        logic        nan;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk1(input string name, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int idx);
        a        = vecs[idx].a;
        b        = vecs[idx].b;
        sub      = vecs[idx].sub;
        in_valid = 1'b1;
    endtask

    initial begin
        int          issued, got, stall_left;
        logic        stall_done;
        logic [15:0] held;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = 32'h0; b32 = 32'h0; sub32 = 1'b0; out_ready32 = 1'b1;

        vecs[0]  = '{16'hC49A, 16'h4429, 1'b0, 16'hB710, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0FCC, 16'h8ADB, 1'b0, 16'h0C5E, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h0A6A, 16'h92BA, 1'b0, 16'h9120, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{16'h43E2, 16'h41AC, 1'b1, 16'h3C6C, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'hBA9D, 16'hBA9D, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'h0400, 16'h8001, 1'b0, 16'h0400, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{16'h0000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{16'h3FFF, 16'h1000, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk1("reset out_valid", out_valid, 1'b0);
        chk16("reset s", s, 16'h0000);
        chk1("reset ovf", ovf, 1'b0);
        chk1("reset unf", unf, 1'b0);
        chk1("reset nan", nan, 1'b0);
        chk1("reset in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Back-to-back table: vector c emerges after the third edge following its issue
        for (int c = 0; c < NV + 2; c++) begin
            if (c < NV) drive(c);
            else in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk1($sformatf("tbl%0d in_ready", c), in_ready, 1'b1);
            if (c >= 2) begin
                chk1($sformatf("vec%0d out_valid", c - 2), out_valid, 1'b1);
                chk16($sformatf("vec%0d s", c - 2), s, vecs[c-2].s);
                chk1($sformatf("vec%0d ovf", c - 2), ovf, vecs[c-2].ovf);
                chk1($sformatf("vec%0d unf", c - 2), unf, vecs[c-2].unf);
                chk1($sformatf("vec%0d nan", c - 2), nan, vecs[c-2].nan);
            end else begin
                chk1($sformatf("lead%0d out_valid", c), out_valid, 1'b0);
            end
        end

        // Backpressure: 5 ops, out_ready low for 4 cycles once the first result shows
        issued = 0; got = 0; stall_left = 0; stall_done = 1'b0; held = 16'h0000;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(posedge clk);
            #1;
            if (out_valid && !stall_done) begin
                stall_left = 4;
                stall_done = 1'b1;
                held = s;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                chk1("bp in_ready", in_ready, 1'b0);
                chk16("bp hold s", s, held);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                chk16($sformatf("bp result%0d", got), s, vecs[got].s);
                got++;
            end
            if (issued < 5 && in_ready) begin
                drive(issued);
                issued++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk32("bp delivered", 32'(got), 32'd5);
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk1("bp no duplicate", out_valid, 1'b0);
        end

        // Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            drive(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk1("rst pre out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst async out_valid", out_valid, 1'b0);
        chk16("rst async s", s, 16'h0000);
        chk1("rst async in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk1("rst edge out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk1("rst idle out_valid", out_valid, 1'b0);
        end
        a = 16'h3C00; b = 16'h3C00; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk1("post-rst lat1", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk1("post-rst lat2", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk1("post-rst out_valid", out_valid, 1'b1);
        chk16("post-rst s", s, 16'h4000);

        // Single-precision build
        a32 = 32'h3F800000; b32 = 32'h40000000; in_valid32 = 1'b1;
        @(posedge clk);
        #1;
        a32 = 32'h7F7FFFFF; b32 = 32'h7F7FFFFF;
        @(posedge clk);
        #1;
        in_valid32 = 1'b0;
        @(posedge clk);
        #1;
        chk1("sp0 out_valid", out_valid32, 1'b1);
        chk32("sp0 s", s32, 32'h40400000);
        chk1("sp0 ovf", ovf32, 1'b0);
        @(posedge clk);
        #1;
        chk1("sp1 out_valid", out_valid32, 1'b1);
        chk32("sp1 s", s32, 32'h7F800000);
        chk1("sp1 ovf", ovf32, 1'b1);
        chk1("sp1 in_ready", in_ready32, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fp_adder_pipe.md
FP_ADDER_PIPE -- requirements
Module: fp_adder_pipe

Interface
REQ-001 SHALL provide parameter EXP_W, default 5, exponent field width in bits.
REQ-002 SHALL provide parameter MAN_W, default 10, stored-mantissa field width in bits; word width W = 1+EXP_W+MAN_W (default 16, IEEE half).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port in_valid  input  1  a/b/sub carry an operation this cycle.
REQ-006 SHALL provide port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL provide port a  input  W  operand A, IEEE-754 layout.
REQ-008 SHALL provide port b  input  W  operand B, IEEE-754 layout.
REQ-009 SHALL provide port sub  input  1  1: compute a-b; 0: compute a+b.
REQ-010 SHALL provide port out_valid  output  1  s/flags hold a valid result.
REQ-011 SHALL provide port out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL provide port s  output  W  result.
REQ-013 SHALL provide port ovf  output  1  result overflowed to infinity.
REQ-014 SHALL provide port unf  output  1  nonzero exact result flushed to zero.
REQ-015 SHALL provide port nan  output  1  result is canonical NaN.

Function
REQ-016 SHALL implement a 3-stage pipeline: S1 unpack/compare/align (swap so |X|>=|Y|, right-shift Y with guard/round/sticky), S2 signed mantissa add/sub, S3 leading-zero normalise, round, pack.
REQ-017 SHALL accept an operation on every cycle where in_valid && in_ready (handshake transfer).
REQ-018 SHALL present a result exactly 3 cycles after acceptance when no stall occurs; throughput 1 op/cycle.
REQ-019 SHALL stall globally: stall = out_valid && !out_ready; while stalled all stage registers hold and in_ready = 0.
REQ-020 SHALL drive in_ready = !stall combinationally; in_ready SHALL not depend on in_valid.
REQ-021 SHALL hold s, ovf, unf, nan stable while out_valid && !out_ready.
REQ-022 SHALL insert bubbles (valid=0) for cycles without a transfer; bubbles SHALL not raise out_valid.
REQ-023 SHALL round to nearest, ties to even, using guard/round/sticky; mantissa carry-out from rounding SHALL increment the exponent.
REQ-024 SHALL treat inputs with exponent field 0 (zero/subnormal) as signed zero.
REQ-025 SHALL return +0 for an exact cancellation (x + (-x)), and (+0)+(-0) = +0, (-0)+(-0) = -0.
REQ-026 SHALL, if the rounded exponent >= 2^EXP_W-1, output signed infinity and set ovf.
REQ-027 SHALL, if the normalised exponent <= 0 with nonzero mantissa, output zero with the result's sign and set unf.
REQ-028 SHALL output canonical NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0) and set nan if either input is NaN or the effective operation is inf - inf.
REQ-029 SHALL output correctly signed infinity if exactly one operand (or both, same effective sign) is infinite.
REQ-030 SHALL apply sub by inverting b's sign in S1 before any other processing.
REQ-031 SHALL pipeline each operation's flags alongside its result; flags of different operations SHALL never mix.

Reset
REQ-032 SHALL, while rst_n = 0, clear all stage valid bits, drive out_valid = 0, s = 0, ovf = unf = nan = 0, in_ready = 1.
REQ-033 SHALL discard all in-flight operations on reset assertion mid-operation; the first output after deassertion SHALL come from an operation accepted after deassertion.

Verification
REQ-034 SHALL pass, defaults, out_ready=1, back-to-back: C49A+4429 -> B710; 0FCC+8ADB -> 0C5E; 0A6A+92BA -> 9120; each 3 cycles after acceptance, consecutive cycles.
REQ-035 SHALL pass sub=1: 43E2 - 41AC -> 3C6C; BA9D - BA9D -> 0000 (+0, no flags).
REQ-036 SHALL pass boundaries: 7BFF+7BFF -> 7C00, ovf=1; 7C00+FC00 -> 7E00, nan=1; 0400+8001 -> 0400 (subnormal as zero); 0401-0400 -> 0000, unf=1 (result subnormal).
REQ-037 SHALL pass backpressure: issue 5 ops back-to-back, drop out_ready for 4 cycles once out_valid rises -> in_ready=0 and s held during the stall, all 5 results delivered in order, none lost or duplicated.
REQ-038 SHALL pass reset mid-flight: assert rst_n=0 with 3 ops in the pipe -> out_valid=0 next edge onward; after release, a new op 3C00+3C00 yields 4000 with no stale output before it.
REQ-039 SHALL pass parameter check EXP_W=8, MAN_W=23: 3F800000+40000000 -> 40400000; 7F7FFFFF+7F7FFFFF -> 7F800000, ovf=1.
